// File: rtl/mips_mem_arbiter.sv
// Shares one unified memory bus between the instruction-fetch and data ports of a Harvard
// MIPS core: arbitrates, sequences issue/wait/read-return/acknowledge, and aborts hung accesses.
module mips_mem_arbiter #(
   parameter bit          RR      = 1'b1,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic [31:0] i_readdata,
   output logic        i_valid,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic [31:0] d_readdata,
   output logic        d_valid,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_byteenable,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_readdata,
   input  logic        mem_readdatavalid,
   output logic        busy,
   output logic        timeout
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;
   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT_RD = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic          gnt_d_q, gnt_d_d;     // current access belongs to the data port
   logic          last_d_q, last_d_d;   // most recent grant went to the data port
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [BW-1:0] be_q, be_d;
   logic [DW-1:0] ird_q, ird_d;
   logic [DW-1:0] drd_q, drd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tout_q, tout_d;
   logic          mem_read_q, mem_read_d;
   logic          mem_write_q, mem_write_d;
   logic          i_valid_q, i_valid_d;
   logic          d_valid_q, d_valid_d;
   logic          busy_q, busy_d;
   logic          d_req, pick_d, expired, abort;

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         gnt_d_q     <= 1'b0;
         last_d_q    <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         ird_q       <= '0;
         drd_q       <= '0;
         cnt_q       <= '0;
         tout_q      <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         i_valid_q   <= 1'b0;
         d_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_d_q     <= gnt_d_d;
         last_d_q    <= last_d_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         ird_q       <= ird_d;
         drd_q       <= drd_d;
         cnt_q       <= cnt_d;
         tout_q      <= tout_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         i_valid_q   <= i_valid_d;
         d_valid_q   <= d_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Arbitration, access sequencing and timeout
   always_comb begin
      state_d  = state_q;
      gnt_d_d  = gnt_d_q;
      last_d_d = last_d_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      ird_d    = ird_q;
      drd_d    = drd_q;
      cnt_d    = cnt_q;
      tout_d   = tout_q;
      d_req    = d_read | d_write;
      pick_d   = 1'b0;
      expired  = (cnt_q == CNT_LAST);
      abort    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_read || d_req) begin
               pick_d   = d_req && (!i_read || !RR || !last_d_q);
               gnt_d_d  = pick_d;
               last_d_d = pick_d;
               wr_d     = pick_d && d_write;
               addr_d   = pick_d ? d_address : i_address;
               wdata_d  = d_writedata;
               be_d     = (pick_d && d_write) ? d_byteenable : {BW{1'b1}};
               cnt_d    = '0;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_q + CW'(1);
            if (!mem_waitrequest && wr_q) begin
               state_d = S_DONE;
            end else if (expired) begin
               abort = 1'b1;
            end else if (!mem_waitrequest) begin
               state_d = S_WAIT_RD;
            end
         end
         S_WAIT_RD: begin
            cnt_d = cnt_q + CW'(1);
            if (mem_readdatavalid) begin
               if (gnt_d_q) begin
                  drd_d = mem_readdata;
               end else begin
                  ird_d = mem_readdata;
               end
               state_d = S_DONE;
            end else if (expired) begin
               abort = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A hung access still completes, returning zero data to its owner
      if (abort) begin
         state_d = S_DONE;
         tout_d  = 1'b1;
         if (gnt_d_q) begin
            drd_d = '0;
         end else begin
            ird_d = '0;
         end
      end

      mem_read_d  = (state_d == S_ISSUE) && !wr_d;
      mem_write_d = (state_d == S_ISSUE) && wr_d;
      i_valid_d   = (state_d == S_DONE) && !gnt_d_d;
      d_valid_d   = (state_d == S_DONE) && gnt_d_d;
      busy_d      = (state_d != S_IDLE);
   end

   assign i_readdata     = ird_q;
   assign i_valid        = i_valid_q;
   assign d_readdata     = drd_q;
   assign d_valid        = d_valid_q;
   assign mem_address    = addr_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_writedata  = wdata_q;
   assign mem_byteenable = be_q;
   assign busy           = busy_q;
   assign timeout        = tout_q;

endmodule
